// File: rtl/moore_pkg.sv
// Shared mode encodings and elaboration helpers for the modulo-N stepper.
package moore_pkg;

  localparam logic [1:0] MODE_UP1  = 2'b00;
  localparam logic [1:0] MODE_DN1  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to encode n distinct values (0 for n <= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/moore_modn_stepper_if.sv
// Control/status bundle between the stepper and its driver.
interface moore_modn_stepper_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             err;
  logic             at_zero;
  logic             at_max;

  modport master (
    output en, mode, step, load_val,
    input  count, wrap, err, at_zero, at_max
  );

  modport slave (
    input  en, mode, step, load_val,
    output count, wrap, err, at_zero, at_max
  );

endinterface

// File: rtl/modn_next.sv
// Next-state logic for the modulo-N stepper: next count plus wrap/err flags.
module modn_next
  import moore_pkg::*;
#(
  parameter int unsigned MODULUS = 6,
  parameter int unsigned WIDTH   = 4
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_step,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next_count,
  output logic             o_wrap_next,
  output logic             o_err_next
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH:0]   w_count_ext;
  logic [WIDTH:0]   w_step_ext;
  logic [WIDTH:0]   w_load_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sum_red;
  logic             w_count_bad;

  assign w_count_ext = {1'b0, i_count};
  assign w_step_ext  = {1'b0, i_step};
  assign w_load_ext  = {1'b0, i_load_val};
  // One extra bit so count+step never overflows before the modulus compare.
  assign w_sum       = w_count_ext + w_step_ext;
  assign w_sum_red   = WIDTH'(w_sum - MOD_EXT);
  assign w_count_bad = (w_count_ext >= MOD_EXT);

  always_comb begin
    o_next_count = i_count;
    o_wrap_next  = 1'b0;
    o_err_next   = 1'b0;

    if (w_count_bad) begin
      // Unreachable encoding: recover on any edge, enabled or not.
      o_next_count = '0;
    end else if (i_en) begin
      unique case (i_mode)
        MODE_UP1: begin
          if (i_count == MAX_VAL) begin
            o_next_count = '0;
            o_wrap_next  = 1'b1;
          end else begin
            o_next_count = i_count + ONE;
          end
        end
        MODE_DN1: begin
          if (i_count == '0) begin
            o_next_count = MAX_VAL;
            o_wrap_next  = 1'b1;
          end else begin
            o_next_count = i_count - ONE;
          end
        end
        MODE_STEP: begin
          if (w_step_ext >= MOD_EXT) begin
            o_err_next = 1'b1;
          end else if (w_sum >= MOD_EXT) begin
            o_next_count = w_sum_red;
            o_wrap_next  = 1'b1;
          end else begin
            o_next_count = w_sum[WIDTH-1:0];
          end
        end
        MODE_LOAD: begin
          if (w_load_ext >= MOD_EXT) begin
            o_err_next = 1'b1;
          end else begin
            o_next_count = i_load_val;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/moore_modn_stepper.sv
// Moore modulo-N stepper: registered count/wrap/err with zero/max decode.
module moore_modn_stepper
  import moore_pkg::*;
#(
  parameter int unsigned MODULUS = 6,
  parameter int unsigned WIDTH   = 4
) (
  input  logic                  clock_div,
  input  logic                  reset,
  moore_modn_stepper_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("moore_modn_stepper: MODULUS must be >= 2");
  end
  if (clog2(MODULUS) > WIDTH) begin : g_bad_width
    $error("moore_modn_stepper: WIDTH too small for MODULUS");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_next_count;
  logic             w_wrap_next;
  logic             w_err_next;

  modn_next #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH)
  ) u_next (
    .i_count      (r_count),
    .i_en         (bus.en),
    .i_mode       (bus.mode),
    .i_step       (bus.step),
    .i_load_val   (bus.load_val),
    .o_next_count (w_next_count),
    .o_wrap_next  (w_wrap_next),
    .o_err_next   (w_err_next)
  );

  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_wrap_next;
      r_err   <= w_err_next;
    end
  end

  assign bus.count   = r_count;
  assign bus.wrap    = r_wrap;
  assign bus.err     = r_err;
  assign bus.at_zero = (r_count == '0);
  assign bus.at_max  = (r_count == MAX_VAL);

endmodule

// File: tb/tb_moore_modn_stepper.sv
// Directed bench for moore_modn_stepper at MODULUS=6 and MODULUS=10.
module tb_moore_modn_stepper;
  import moore_pkg::*;

  logic        clock_div = 1'b0;
  logic        reset     = 1'b0;
  int unsigned n_vec     = 0;
  int unsigned n_bad     = 0;

  moore_modn_stepper_if #(.WIDTH(4)) bus6 ();
  moore_modn_stepper_if #(.WIDTH(4)) bus10 ();

  moore_modn_stepper #(.MODULUS(6), .WIDTH(4)) dut6 (
    .clock_div (clock_div),
    .reset     (reset),
    .bus       (bus6)
  );

  moore_modn_stepper #(.MODULUS(10), .WIDTH(4)) dut10 (
    .clock_div (clock_div),
    .reset     (reset),
    .bus       (bus10)
  );

  always #5 clock_div = ~clock_div;

  task automatic tick();
    @(posedge clock_div);
    #1;
  endtask

  task automatic drive6(input logic en, input logic [1:0] mode, input logic [3:0] step,
                        input logic [3:0] ld);
    bus6.en = en; bus6.mode = mode; bus6.step = step; bus6.load_val = ld;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (bus6.count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", bus6.count); end
    n_vec++; if (bus6.wrap !== 1'b0) begin n_bad++; $display("FAIL rst_wrap got %b want 0", bus6.wrap); end
    n_vec++; if (bus6.err !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", bus6.err); end
    n_vec++; if (bus6.at_zero !== 1'b1) begin n_bad++; $display("FAIL rst_at_zero got %b want 1", bus6.at_zero); end
    n_vec++; if (bus6.at_max !== 1'b0) begin n_bad++; $display("FAIL rst_at_max got %b want 0", bus6.at_max); end
    reset = 1'b1;
    drive6(1'b1, MODE_UP1, 4'd0, 4'd0);
    repeat (4) tick();
    n_vec++; if (bus6.count !== 4'd4) begin n_bad++; $display("FAIL pre_rst_count got %0d want 4", bus6.count); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (bus6.count !== 4'd0) begin n_bad++; $display("FAIL async_rst_count got %0d want 0", bus6.count); end
    n_vec++; if (bus6.at_zero !== 1'b1) begin n_bad++; $display("FAIL async_rst_at_zero got %b want 1", bus6.at_zero); end
    n_vec++; if (bus6.err !== 1'b0 || bus6.wrap !== 1'b0) begin
      n_bad++; $display("FAIL async_rst_flags got wrap=%b err=%b want 0/0", bus6.wrap, bus6.err);
    end
    drive6(1'b0, MODE_UP1, 4'd0, 4'd0);
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_up();
    logic [3:0] exp_cnt [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
    logic       exp_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_max [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    drive6(1'b1, MODE_UP1, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      n_vec++; if (bus6.count !== exp_cnt[i]) begin
        n_bad++; $display("FAIL up_count[%0d] got %0d want %0d", i, bus6.count, exp_cnt[i]);
      end
      n_vec++; if (bus6.wrap !== exp_wrap[i]) begin
        n_bad++; $display("FAIL up_wrap[%0d] got %b want %b", i, bus6.wrap, exp_wrap[i]);
      end
      n_vec++; if (bus6.at_max !== exp_max[i]) begin
        n_bad++; $display("FAIL up_at_max[%0d] got %b want %b", i, bus6.at_max, exp_max[i]);
      end
    end
  endtask

  task automatic test_down();
    drive6(1'b1, MODE_LOAD, 4'd0, 4'd0);
    tick();
    n_vec++; if (bus6.count !== 4'd0) begin n_bad++; $display("FAIL dn_load0 got %0d want 0", bus6.count); end
    drive6(1'b1, MODE_DN1, 4'd0, 4'd0);
    tick();
    n_vec++; if (bus6.count !== 4'd5) begin n_bad++; $display("FAIL dn_under_count got %0d want 5", bus6.count); end
    n_vec++; if (bus6.wrap !== 1'b1) begin n_bad++; $display("FAIL dn_under_wrap got %b want 1", bus6.wrap); end
    n_vec++; if (bus6.at_max !== 1'b1) begin n_bad++; $display("FAIL dn_at_max got %b want 1", bus6.at_max); end
    tick();
    n_vec++; if (bus6.count !== 4'd4) begin n_bad++; $display("FAIL dn_count got %0d want 4", bus6.count); end
    n_vec++; if (bus6.wrap !== 1'b0) begin n_bad++; $display("FAIL dn_wrap got %b want 0", bus6.wrap); end
  endtask

  task automatic test_step();
    drive6(1'b1, MODE_LOAD, 4'd0, 4'd3);
    tick();
    n_vec++; if (bus6.count !== 4'd3) begin n_bad++; $display("FAIL st_load3 got %0d want 3", bus6.count); end
    drive6(1'b1, MODE_STEP, 4'd4, 4'd0);
    tick();
    n_vec++; if (bus6.count !== 4'd1) begin n_bad++; $display("FAIL st4_count got %0d want 1", bus6.count); end
    n_vec++; if (bus6.wrap !== 1'b1) begin n_bad++; $display("FAIL st4_wrap got %b want 1", bus6.wrap); end
    drive6(1'b1, MODE_STEP, 4'd6, 4'd0);
    tick();
    n_vec++; if (bus6.count !== 4'd1) begin n_bad++; $display("FAIL st6_count got %0d want 1", bus6.count); end
    n_vec++; if (bus6.err !== 1'b1) begin n_bad++; $display("FAIL st6_err got %b want 1", bus6.err); end
    n_vec++; if (bus6.wrap !== 1'b0) begin n_bad++; $display("FAIL st6_wrap got %b want 0", bus6.wrap); end
    drive6(1'b1, MODE_STEP, 4'd0, 4'd0);
    tick();
    n_vec++; if (bus6.count !== 4'd1) begin n_bad++; $display("FAIL st0_count got %0d want 1", bus6.count); end
    n_vec++; if (bus6.err !== 1'b0 || bus6.wrap !== 1'b0) begin
      n_bad++; $display("FAIL st0_flags got wrap=%b err=%b want 0/0", bus6.wrap, bus6.err);
    end
  endtask

  task automatic test_load();
    drive6(1'b1, MODE_LOAD, 4'd0, 4'd2);
    tick();
    n_vec++; if (bus6.count !== 4'd2) begin n_bad++; $display("FAIL ld2_count got %0d want 2", bus6.count); end
    n_vec++; if (bus6.err !== 1'b0) begin n_bad++; $display("FAIL ld2_err got %b want 0", bus6.err); end
    drive6(1'b1, MODE_LOAD, 4'd0, 4'd7);
    tick();
    n_vec++; if (bus6.count !== 4'd2) begin n_bad++; $display("FAIL ld7_count got %0d want 2", bus6.count); end
    n_vec++; if (bus6.err !== 1'b1) begin n_bad++; $display("FAIL ld7_err got %b want 1", bus6.err); end
    tick();
    n_vec++; if (bus6.err !== 1'b1) begin n_bad++; $display("FAIL ld7_err_b2b got %b want 1", bus6.err); end
    drive6(1'b0, MODE_LOAD, 4'd0, 4'd4);
    tick();
    n_vec++; if (bus6.count !== 4'd2) begin n_bad++; $display("FAIL en0_count got %0d want 2", bus6.count); end
    n_vec++; if (bus6.err !== 1'b0) begin n_bad++; $display("FAIL en0_err got %b want 0", bus6.err); end
  endtask

  task automatic test_mod10();
    logic [3:0] exp_cnt [5] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    logic       exp_wrap [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus10.en = 1'b1; bus10.mode = MODE_STEP; bus10.step = 4'd9; bus10.load_val = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (bus10.count !== exp_cnt[i]) begin
        n_bad++; $display("FAIL m10_count[%0d] got %0d want %0d", i, bus10.count, exp_cnt[i]);
      end
      n_vec++; if (bus10.wrap !== exp_wrap[i]) begin
        n_bad++; $display("FAIL m10_wrap[%0d] got %b want %b", i, bus10.wrap, exp_wrap[i]);
      end
      if (i == 0) begin
        n_vec++; if (bus10.at_max !== 1'b1) begin
          n_bad++; $display("FAIL m10_at_max got %b want 1", bus10.at_max);
        end
      end
    end
    bus10.en = 1'b0;
  endtask

  initial begin
    drive6(1'b0, MODE_UP1, 4'd0, 4'd0);
    bus10.en = 1'b0; bus10.mode = MODE_UP1; bus10.step = 4'd0; bus10.load_val = 4'd0;
    test_reset();
    test_up();
    test_down();
    test_step();
    test_load();
    test_mod10();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/moore_modn_stepper.md
Name: moore_modn_stepper

Overview:
- Parametrised Moore-style modulo-N state counter: a registered state value advanced once per clock_div edge by a selectable mode (up 1, down 1, up by programmable step, load).
- All outputs depend only on registered state.
- Generalises the fixed 6-state sequencer to arbitrary modulus and width, and adds enable, load, range checking and boundary flags.
- Sits behind the board clock divider and drives 7-segment/LED decode logic.

Parameters:
MODULUS, 6, number of states; legal state values 0..MODULUS-1; must be >= 2
WIDTH, 4, width of count/step/load_val; 2**WIDTH >= MODULUS is a hard requirement (elaboration error otherwise)

Ports:
clock_div  input  1  divided system clock; all state changes on posedge
reset  input  1  asynchronous, active-low; forces reset state immediately
en  input  1  advance enable; 0 = hold state (wrap and err still update, to 0)
mode  input  2  00 up-by-1, 01 down-by-1, 10 up-by-step, 11 load
step  input  WIDTH  increment for mode 10; legal 0..MODULUS-1
load_val  input  WIDTH  value for mode 11; legal 0..MODULUS-1
count  output  WIDTH  current state (registered)
wrap  output  1  registered; 1 for exactly the cycle after a transition that crossed MODULUS-1->0 (up) or 0->MODULUS-1 (down)
err  output  1  registered; 1 for the cycle after an illegal step/load request
at_zero  output  1  decode: count == 0
at_max  output  1  decode: count == MODULUS-1

Behaviour:
- Reset (reset=0, async): count=0, wrap=0, err=0; hence at_zero=1, at_max=0. Release is synchronous to the next clock_div edge; the first update occurs on the first posedge with reset=1.
- Latency: inputs sampled at posedge; count/wrap/err valid after that edge; one cycle, no pipelining.
- en=0: count holds; wrap<=0; err<=0, regardless of mode/step/load_val.
- en=1, mode 00: count <= (count==MODULUS-1) ? 0 : count+1; wrap<=1 only on the rollover.
- en=1, mode 01: count <= (count==0) ? MODULUS-1 : count-1; wrap<=1 only on the underflow.
- en=1, mode 10:
  - if step >= MODULUS: hold; err<=1; wrap<=0.
  - else sum = count+step computed in WIDTH+1 bits; count <= (sum>=MODULUS) ? sum-MODULUS : sum; wrap<=1 iff sum>=MODULUS.
  - step=0 holds with wrap=0, err=0.
- en=1, mode 11:
  - if load_val >= MODULUS: hold; err<=1.
  - else count<=load_val; err<=0.
  - wrap<=0 always in this mode.
- Invariant: count never leaves 0..MODULUS-1. Unreachable encodings (count>=MODULUS) recover to 0 on the next enabled edge, or the next edge if en=0.
- Flags: wrap and err are single-cycle; back-to-back qualifying cycles keep them high continuously. at_zero and at_max are purely combinational from count. MODULUS=2 gives at_zero/at_max complementary.
- Reset asserted mid-sequence clears everything immediately, independent of clock.

Decomposition:
- Shared package moore_pkg holds the mode encodings MODE_UP1=2'b00, MODE_DN1=2'b01, MODE_STEP=2'b10, MODE_LOAD=2'b11, and a clog2 helper for width checks.
- One combinational sub-module, modn_next (params MODULUS, WIDTH), computes next_count, wrap_next and err_next from count/en/mode/step/load_val.
- The top block holds the registers and the at_zero/at_max decode.

Test Plan:
1. MODULUS=6: reset low mid-run with count=4 -> count=0, wrap=0, err=0, at_zero=1 immediately (before any edge).
2. en=1, mode 00, 7 edges from 0 -> count 1,2,3,4,5,0,1; wrap=1 only after the 6th edge; at_max=1 while count=5.
3. Mode 01 from 0 -> count=5, wrap=1; next edge -> 4, wrap=0.
4. Mode 10: step=4 from count=3 -> count=1, wrap=1; step=6 -> count holds at 1, err=1 one cycle; step=0 -> hold, err=0.
5. Mode 11: load_val=2 -> count=2; load_val=7 -> hold at 2, err=1; en=0 with mode 11 and load_val=4 -> count stays 2, err=0.
6. MODULUS=10, WIDTH=4: mode 10, step=9 repeatedly from 0 -> 9,8,7,...; wrap=1 on every step except the first.
